// File: rtl/contra_pal_pkg.sv
// contra_pal_pkg: shared types and constants for the palette encoder slice.
// Holds the RGB444 pixel struct, palette/distance sizing constants, the
// encoder FSM state enum and a small per-channel absolute difference helper.
package contra_pal_pkg;

    // One RGB444 pixel, packed as {red, green, blue}.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int PAL_ENTRIES = 8;
    localparam int IDX_W       = 3;
    localparam int DIST_W      = 6;

    // Larger than any real L1 distance (max 45), so entry 0 always wins first.
    localparam logic [DIST_W-1:0] DIST_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } pal_state_e;

    // Absolute difference of two unsigned 4-bit channel values.
    function automatic logic [3:0] absDiff4(input logic [3:0] x, input logic [3:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/contra_rgb_distance.sv
// contra_rgb_distance: combinational L1 distance between two RGB444 colours.
// Each channel term is 0..15, so the 6-bit sum tops out at 45 and never wraps.
module contra_rgb_distance
    import contra_pal_pkg::*;
(
    input  rgb444_t           a_i,
    input  rgb444_t           b_i,
    output logic [DIST_W-1:0] dist_o
);

    logic [3:0] diffR;
    logic [3:0] diffG;
    logic [3:0] diffB;

    // Per-channel magnitudes widened before summing so the carry is kept.
    always_comb begin
        diffR  = absDiff4(a_i.r, b_i.r);
        diffG  = absDiff4(a_i.g, b_i.g);
        diffB  = absDiff4(a_i.b, b_i.b);
        dist_o = DIST_W'(diffR) + DIST_W'(diffG) + DIST_W'(diffB);
    end

endmodule

// File: rtl/contra_palette_encoder.sv
// contra_palette_encoder: maps a 12-bit RGB444 pixel to the 3-bit index of the
// nearest entry in a loadable 8-entry palette, scanning one entry per clock.
// Optional build macro: CONTRA_PAL_EARLY_EXIT_EN - when defined, an exact
// colour match (distance 0) ends the scan immediately; results are unchanged.
module contra_palette_encoder
    import contra_pal_pkg::*;
#(
    parameter int PAL_ENTRIES = contra_pal_pkg::PAL_ENTRIES,
    parameter int IDX_W       = contra_pal_pkg::IDX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [11:0]       pal_wdata,
    output logic              pal_wready,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [11:0]       s_rgb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [IDX_W-1:0]  m_index,
    output logic [DIST_W-1:0] m_dist
);

    pal_state_e        state_q;
    pal_state_e        state_d;
    rgb444_t           palette_q [PAL_ENTRIES];
    rgb444_t           pixel_q;
    rgb444_t           pixel_d;
    logic [IDX_W-1:0]  scanIdx_q;
    logic [IDX_W-1:0]  scanIdx_d;
    logic [IDX_W-1:0]  bestIdx_q;
    logic [IDX_W-1:0]  bestIdx_d;
    logic [DIST_W-1:0] bestDist_q;
    logic [DIST_W-1:0] bestDist_d;
    logic [DIST_W-1:0] curDist;
    logic              lastEntry;
    logic              palWrite;

    // Single shared distance unit, fed by the entry currently under scan.
    contra_rgb_distance uDistance (
        .a_i    (pixel_q),
        .b_i    (palette_q[scanIdx_q]),
        .dist_o (curDist)
    );

    // Handshake outputs; the Reset gating keeps everything quiet while reset is held.
    always_comb begin
        s_ready    = 1'b0;
        pal_wready = 1'b0;
        m_valid    = 1'b0;
        m_index    = '0;
        m_dist     = '0;
        if (!Reset) begin
            s_ready    = (state_q == ST_IDLE);
            pal_wready = (state_q == ST_IDLE);
            m_valid    = (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                m_index = bestIdx_q;
                m_dist  = bestDist_q;
            end
        end
        palWrite  = pal_we && pal_wready;
        lastEntry = (scanIdx_q == IDX_W'(PAL_ENTRIES - 1));
    end

    // Palette storage; writes only land while idle so a running scan sees a frozen table.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int e = 0; e < PAL_ENTRIES; e++) begin
                palette_q[e] <= '0;
            end
        end else if (palWrite) begin
            palette_q[pal_waddr] <= rgb444_t'(pal_wdata);
        end
    end

    // Next-state logic: accept in IDLE, compare one entry per cycle, hold in DONE.
    always_comb begin
        state_d    = state_q;
        pixel_d    = pixel_q;
        scanIdx_d  = scanIdx_q;
        bestIdx_d  = bestIdx_q;
        bestDist_d = bestDist_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    pixel_d    = rgb444_t'(s_rgb);
                    scanIdx_d  = '0;
                    bestIdx_d  = '0;
                    bestDist_d = DIST_MAX;
                    state_d    = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // Strict less-than: on a tie the earlier (lower) index is kept.
                if (curDist < bestDist_q) begin
                    bestIdx_d  = scanIdx_q;
                    bestDist_d = curDist;
                end
                scanIdx_d = scanIdx_q + IDX_W'(1);
                if (lastEntry) begin
                    state_d = ST_DONE;
                end
`ifdef CONTRA_PAL_EARLY_EXIT_EN
                // Nothing can beat an exact hit, so stop scanning right here.
                if (curDist == '0) begin
                    state_d = ST_DONE;
                end
`else
`endif
            end
            ST_DONE: begin
                // Going back through IDLE guarantees no accept on the consuming edge.
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Search state registers; reset abandons any pixel in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            pixel_q    <= '0;
            scanIdx_q  <= '0;
            bestIdx_q  <= '0;
            bestDist_q <= '0;
        end else begin
            state_q    <= state_d;
            pixel_q    <= pixel_d;
            scanIdx_q  <= scanIdx_d;
            bestIdx_q  <= bestIdx_d;
            bestDist_q <= bestDist_d;
        end
    end

endmodule
